// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, key/word types, round constants
// and inverse key generator states (ST_FWD exists only with INV_KEY_GEN_FWD_EXPAND_EN).
package aes_pkg;

   localparam int NUM_ROUNDS = 10;

   typedef logic [127:0] aes_key_t;
   typedef logic [31:0]  aes_word_t;

   // rcon(0) sits in the top byte, rcon(9) in the bottom byte.
   localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

`ifdef INV_KEY_GEN_FWD_EXPAND_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_EMIT = 2'd2
   } inv_key_state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd2
   } inv_key_state_t;
`endif

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] val;
      if (idx < 4'd10) begin
         val = RCON_TABLE[32'sd8 * (32'sd9 - int'(idx)) +: 32'd8];
      end else begin
         val = 8'h00;
      end
      return val;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte in, one byte out, pure lookup.
module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   // Entry for input 8'h00 occupies the top byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/inv_key_step.sv
// One combinational key-schedule step: round key r -> round key r-1; with
// INV_KEY_GEN_FWD_EXPAND_EN the same S-boxes also serve the forward step r -> r+1.
module inv_key_step
   import aes_pkg::*;
(
   input  logic [127:0] key_in,
   input  logic [3:0]   round,
`ifdef INV_KEY_GEN_FWD_EXPAND_EN
   input  logic         fwd,
`endif
   output logic [127:0] key_out
);

   aes_word_t w0, w1, w2, w3;
   aes_word_t n0, n1, n2, n3;
   aes_word_t sub_in, rot, sub_out;
   logic [7:0] rc_inv;

   assign {w0, w1, w2, w3} = key_in;

   // The inverse step recovers W3 first, so that word drives the S-boxes.
   assign n3 = w3 ^ w2;
   assign n2 = w2 ^ w1;
   assign n1 = w1 ^ w0;
   assign rc_inv = rcon(round - 4'd1);

`ifdef INV_KEY_GEN_FWD_EXPAND_EN
   aes_word_t f0, f1, f2, f3;
   logic [7:0] rc_fwd;

   assign sub_in = fwd ? w3 : n3;
   assign rc_fwd = rcon(round);
`else
   assign sub_in = n3;
`endif

   assign rot = {sub_in[23:0], sub_in[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .in_byte  (rot[8*i +: 8]),
         .out_byte (sub_out[8*i +: 8])
      );
   end

   assign n0 = w0 ^ sub_out ^ {rc_inv, 24'h000000};

`ifdef INV_KEY_GEN_FWD_EXPAND_EN
   assign f0 = w0 ^ sub_out ^ {rc_fwd, 24'h000000};
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;
   assign key_out = fwd ? {f0, f1, f2, f3} : {n0, n1, n2, n3};
`else
   assign key_out = {n0, n1, n2, n3};
`endif

endmodule

// File: rtl/inv_key_generation.sv
// Iterative AES-128 inverse key schedule: emits round keys 10..0, one per handshake.
// INV_KEY_GEN_FWD_EXPAND_EN: key_in is the cipher key, expanded forward in place first.
module inv_key_generation
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic [127:0] key_out,
   output logic [3:0]   key_round,
   output logic         key_valid,
   input  logic         key_ready,
   output logic         busy,
   output logic         done
);

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   inv_key_state_t state_r, state_nxt;
   logic [127:0]   key_nxt, step_key;
   logic [3:0]     round_nxt;
   logic           valid_nxt, done_nxt;

`ifdef INV_KEY_GEN_FWD_EXPAND_EN
   logic fwd_sel;

   assign fwd_sel = (state_r == ST_FWD);
`endif

   inv_key_step u_step (
      .key_in  (key_out),
      .round   (key_round),
`ifdef INV_KEY_GEN_FWD_EXPAND_EN
      .fwd     (fwd_sel),
`endif
      .key_out (step_key)
   );

   // Next-state, key register and handshake decode.
   always_comb begin
      state_nxt = state_r;
      key_nxt   = key_out;
      round_nxt = key_round;
      valid_nxt = key_valid;
      done_nxt  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               key_nxt = key_in;
`ifdef INV_KEY_GEN_FWD_EXPAND_EN
               round_nxt = 4'd0;
               valid_nxt = 1'b0;
               state_nxt = ST_FWD;
`else
               round_nxt = LAST_ROUND;
               valid_nxt = 1'b1;
               state_nxt = ST_EMIT;
`endif
            end else begin
               valid_nxt = 1'b0;
            end
         end
`ifdef INV_KEY_GEN_FWD_EXPAND_EN
         ST_FWD: begin
            key_nxt = step_key;
            if (key_round == LAST_ROUND - 4'd1) begin
               round_nxt = LAST_ROUND;
               valid_nxt = 1'b1;
               state_nxt = ST_EMIT;
            end else begin
               round_nxt = key_round + 4'd1;
            end
         end
`endif
         ST_EMIT: begin
            if (key_ready) begin
               if (key_round != 4'd0) begin
                  key_nxt   = step_key;
                  round_nxt = key_round - 4'd1;
               end else begin
                  valid_nxt = 1'b0;
                  done_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end else begin
               state_nxt = ST_EMIT;
            end
         end
         default: begin
            valid_nxt = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         key_out   <= 128'h0;
         key_round <= 4'd0;
         key_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_r   <= state_nxt;
         key_out   <= key_nxt;
         key_round <= round_nxt;
         key_valid <= valid_nxt;
         busy      <= (state_nxt != ST_IDLE);
         done      <= done_nxt;
      end
   end

endmodule

// File: doc/inv_key_generation.md
Name: inv_key_generation

Overview:
- Iterative AES-128 inverse key schedule for the decryption datapath.
- Takes the round-10 key and emits round keys 10, 9, …, 0 in that order, one per accepted handshake.
- Steps backward one round per accept, so no round-key table is stored.
- Sits between the key loader and the inverse-round engine. It is the reverse-direction counterpart of the forward key generator.

Parameters:
- NUM_ROUNDS, 10, number of AES rounds. Fixed at 10; only AES-128 is supported. Any other value is illegal.

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- Start  in  1  one-cycle request; sampled only in IDLE
- Key_In  in  128  round-10 key (or the cipher key when FWD_EXPAND_EN is defined); sampled with Start
- Key_Out  out  128  current round key, words W0..W3 at [127:96]..[31:0]
- Key_Round  out  4  round index of Key_Out (10 down to 0)
- Key_Valid  out  1  Key_Out/Key_Round are valid
- Key_Ready  in  1  consumer accepts Key_Out when Key_Valid & Key_Ready
- Busy  out  1  high in any state other than IDLE
- Done  out  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset (async, Rst_n=0):
  - State = IDLE; Key_Out=0, Key_Round=0, Key_Valid=0, Busy=0, Done=0.
  - Reset mid-operation abandons the sequence immediately; no Done.
- States: IDLE -> (FWD when macro defined) -> EMIT -> IDLE.
- IDLE:
  - Start=1 loads Key_In into the key register.
  - Sets Key_Round=10 and goes to EMIT.
  - Key_Valid=1 the cycle after Start, so latency is 1 cycle.
- EMIT:
  - Key_Valid=1; Key_Out and Key_Round are held stable while Key_Ready=0.
  - On accept with Key_Round>0, the register is replaced by the previous round key, Key_Round decrements, and Key_Valid stays 1. Back-to-back accepts give one key per cycle.
  - On accept with Key_Round=0: go to IDLE, Key_Valid=0, Done=1 for one cycle.
- Inverse step from round r to round r-1 (words W0..W3 of round r):
  - W3' = W3 ^ W2
  - W2' = W2 ^ W1
  - W1' = W1 ^ W0
  - W0' = W0 ^ SubWord(RotWord(W3')) ^ rcon(r-1)
- RotWord and rcon:
  - RotWord takes bytes [23:16],[15:8],[7:0],[31:24] of W3'.
  - rcon(0..9) = 01,02,04,08,10,20,40,80,1b,36 in bits [31:24], lower bytes 0.
- SubWord uses four instances of the existing forward sbox. The forward S-box is correct in both directions of the schedule.
- Start while Busy=1 is ignored, including in the Done cycle's predecessor.
- Start in the cycle Done=1 (state is IDLE) is accepted.
- Key_Ready while Key_Valid=0 is ignored.
- Key_Round never wraps below 0.

Optional Feature:
- Macro: INV_KEY_GEN_FWD_EXPAND_EN
- Defined:
  - Key_In is the cipher key (round 0).
  - Start enters FWD, which runs 10 forward expansion steps, one per cycle, in the same register, using the same sbox instances muxed on the word input.
  - Then enters EMIT with Key_Round=10.
  - Key_Valid rises 11 cycles after Start. Busy=1 throughout FWD.
- Not defined:
  - FWD state and its mux are absent.
  - Key_In must be the round-10 key; latency 1 cycle.

Decomposition:
- Shared package aes_pkg:
  - NUM_ROUNDS constant, 128-bit key and 32-bit word typedefs.
  - RCON constant table, shared with the forward key generator.
  - State enum for this block.
- One natural sub-module: inv_key_step, combinational, (round key r, r) -> round key r-1, containing the four sbox instances.
- The FSM, counter and handshake stay in inv_key_generation.

Test Plan:
- FIPS-197 walk (macro off):
  - Stimulus: Start with Key_In=d014f9a8c9ee2589e13f0cc8b6630ca6, Key_Ready=1.
  - Required: Key_Round 10 key equals input; Key_Round 9 = ac7766f319fadc2128d12941575c006e; Key_Round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: 11 consecutive valid cycles, then Done pulse.
- Backpressure:
  - Stimulus: Key_Ready toggled randomly.
  - Required: Key_Out/Key_Round never change while Key_Valid=1 and Key_Ready=0; sequence identical to the walk.
- Ignored/back-to-back Start:
  - Stimulus: Start pulsed at Key_Round=5.
  - Required: no effect.
  - Stimulus: Start in the Done cycle.
  - Required: new sequence begins with Key_Round=10 next cycle.
- Reset mid-operation:
  - Stimulus: Rst_n low at Key_Round=4.
  - Required: all outputs 0 asynchronously, no Done; subsequent Start runs normally.
- Macro on:
  - Stimulus: Start with Key_In=2b7e151628aed2a6abf7158809cf4f3c.
  - Required: Busy=1, Key_Valid=0 for 10 cycles; Key_Valid at cycle 11 with Key_Out=d014f9a8c9ee2589e13f0cc8b6630ca6, Key_Round=10.
- All-zero key:
  - Stimulus: forward-expand 000…0 with a reference model and feed its round-10 key.
  - Required: round 0 returns 00000000000000000000000000000000.
